// File: rtl/store_merge_if.sv
// Store-path bus: datapath request side plus word-addressed memory side.
interface store_merge_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              done;
    logic              err;

    // The store unit itself
    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_wr, mem_wdata, done, err
    );

    // Datapath / memory model driving the unit
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_wr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Read-modify-write store unit: byte/half stores read the aligned word, merge
// the store data into the addressed lanes and write it back; word stores skip
// the read. Optional macro STORE_ALIGN_CHK_EN turns misaligned/reserved
// requests into an err+done pulse with no memory access.
module store_merge_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    store_merge_if.slave  bus
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [OFF_W-1:0]  r_off,       w_off_nxt;
    logic [15:0]       r_data,      w_data_nxt;
    logic [1:0]        r_size,      w_size_nxt;
    logic              r_ready,     w_ready_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic              r_mem_wr,    w_mem_wr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;

    logic [ADDR_W-1:0] w_aligned;
    logic              w_fault;
    logic              w_fault_err;

    // Replace the addressed lane(s) of the read word with the store data
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] rd,
        input logic [15:0]       wd,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        sz
    );
        logic [DATA_W-1:0] res;
        res = rd;
        for (int i = 0; i < int'(LANES); i++) begin
            if (sz == SZ_BYTE && OFF_W'(i) == off) begin
                res[i*8 +: 8] = wd[7:0];
            end else if (sz == SZ_HALF &&
                         (OFF_W'(i) | OFF_W'(1)) == (off | OFF_W'(1))) begin
                res[i*8 +: 8] = ((i % 2) == 0) ? wd[7:0] : wd[15:8];
            end
        end
        return res;
    endfunction

    assign w_aligned = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

`ifdef STORE_ALIGN_CHK_EN
    // Reserved size, odd half address and unaligned word all fault
    assign w_fault     = (bus.req_size == 2'b11) ||
                         (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                         (bus.req_size == SZ_WORD && bus.req_addr[OFF_W-1:0] != '0);
    assign w_fault_err = 1'b1;
`else
    // Only the reserved size takes the no-access path; misalignment is dropped
    assign w_fault     = (bus.req_size == 2'b11);
    assign w_fault_err = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_off_nxt       = r_off;
        w_data_nxt      = r_data;
        w_size_nxt      = r_size;
        w_ready_nxt     = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wr_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (bus.req_valid && r_ready) begin
                    w_ready_nxt = 1'b0;
                    w_off_nxt   = bus.req_addr[OFF_W-1:0];
                    w_data_nxt  = bus.req_data[15:0];
                    w_size_nxt  = bus.req_size;
                    if (w_fault) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = w_fault_err;
                    end else if (bus.req_size == SZ_WORD) begin
                        w_state_nxt     = S_WRITE;
                        w_mem_addr_nxt  = w_aligned;
                        w_mem_wdata_nxt = bus.req_data;
                        w_mem_wr_nxt    = 1'b1;
                        w_done_nxt      = 1'b1;
                    end else begin
                        w_state_nxt    = S_READ;
                        w_cnt_nxt      = CNT_W'(RD_LAT - 1);
                        w_mem_addr_nxt = w_aligned;
                    end
                end
            end
            S_READ: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = S_WRITE;
                    w_mem_wdata_nxt = f_merge(bus.mem_rdata, r_data, r_off, r_size);
                    w_mem_wr_nxt    = 1'b1;
                    w_done_nxt      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any store in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_off       <= '0;
            r_data      <= '0;
            r_size      <= '0;
            r_ready     <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_off       <= w_off_nxt;
            r_data      <= w_data_nxt;
            r_size      <= w_size_nxt;
            r_ready     <= w_ready_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: three instances (32b/RD_LAT=1, 64b/RD_LAT=3,
// 32b/RD_LAT=2) with a per-instance scoreboard of expected completions.
module tb_store_merge_unit;
`ifdef STORE_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          wr;
        bit          er;
        logic [63:0] addr;
        logic [63:0] wdata;
    } exp_t;

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        bit          wr;
        bit          er;
        int          lat;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;

    exp_t        q32[$];
    exp_t        q64[$];
    exp_t        q2[$];
    logic [63:0] lasta[3];
    logic [63:0] lastw[3];
    vec_t        vecs[10];

    store_merge_if #(.DATA_W(32), .ADDR_W(32)) b32();
    store_merge_if #(.DATA_W(64), .ADDR_W(32)) b64();
    store_merge_if #(.DATA_W(32), .ADDR_W(32)) b2();

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u32 (
        .clk(clk), .reset_n(reset_n), .bus(b32.slave));
    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) u64 (
        .clk(clk), .reset_n(reset_n), .bus(b64.slave));
    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(2)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h (cyc %0d)", nm, id, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q32.size();
            1:       return q64.size();
            default: return q2.size();
        endcase
    endfunction

    // Scoreboard monitor for one instance, called once per cycle
    task automatic mon(input int id, input logic done, input logic wr, input logic er,
                       input logic [63:0] addr, input logic [63:0] wdata);
        exp_t e;
        bit   have;
        have = 1'b0;
        chk("wr_implies_done", id, 64'(wr & ~done), 64'(0));
        if (done) begin
            case (id)
                0: if (q32.size() != 0) begin e = q32.pop_front(); have = 1'b1; end
                1: if (q64.size() != 0) begin e = q64.pop_front(); have = 1'b1; end
                default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk("unexpected_done", id, 64'(done), 64'(0));
            end else begin
                chk("done_cycle", id, 64'(cyc), 64'(e.cyc));
                chk("mem_wr", id, 64'(wr), 64'(e.wr));
                chk("err", id, 64'(er), 64'(e.er));
                if (e.wr) begin
                    chk("mem_addr", id, addr, e.addr);
                    chk("mem_wdata", id, wdata, e.wdata);
                    lasta[id] = e.addr;
                    lastw[id] = e.wdata;
                end else begin
                    chk("addr_hold", id, addr, lasta[id]);
                    chk("wdata_hold", id, wdata, lastw[id]);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon(0, b32.done, b32.mem_wr, b32.err, 64'(b32.mem_addr), 64'(b32.mem_wdata));
        mon(1, b64.done, b64.mem_wr, b64.err, 64'(b64.mem_addr), 64'(b64.mem_wdata));
        mon(2, b2.done,  b2.mem_wr,  b2.err,  64'(b2.mem_addr),  64'(b2.mem_wdata));
    endtask

    function automatic logic get_ready(input int id);
        case (id)
            0:       return b32.req_ready;
            1:       return b64.req_ready;
            default: return b2.req_ready;
        endcase
    endfunction

    task automatic drain(input int id);
        for (int k = 0; k < 40 && qsize(id) != 0; k++) step();
        chk("drain_timeout", id, 64'(qsize(id)), 64'(0));
    endtask

    task automatic wait_ready(input int id);
        for (int k = 0; k < 20 && !get_ready(id); k++) step();
        chk("ready_idle", id, 64'(get_ready(id)), 64'(1));
    endtask

    // One store on instance id; e.cyc carries the latency on entry
    task automatic send(input int id, input logic [31:0] addr, input logic [63:0] data,
                        input logic [1:0] sz, input logic [63:0] rdata, input exp_t e);
        wait_ready(id);
        e.cyc = cyc + e.cyc;
        case (id)
            0: begin
                b32.req_addr = addr; b32.req_data = 32'(data); b32.req_size = sz;
                b32.mem_rdata = 32'(rdata); b32.req_valid = 1'b1; q32.push_back(e);
            end
            1: begin
                b64.req_addr = addr; b64.req_data = data; b64.req_size = sz;
                b64.mem_rdata = rdata; b64.req_valid = 1'b1; q64.push_back(e);
            end
            default: begin
                b2.req_addr = addr; b2.req_data = 32'(data); b2.req_size = sz;
                b2.mem_rdata = 32'(rdata); b2.req_valid = 1'b1; q2.push_back(e);
            end
        endcase
        step();
        b32.req_valid = 1'b0;
        b64.req_valid = 1'b0;
        b2.req_valid  = 1'b0;
        drain(id);
    endtask

    task automatic check_reset_vals(input int id, input logic rdy, input logic wr, input logic dn,
                                    input logic er, input logic [63:0] addr, input logic [63:0] wdata);
        chk("rst_ready", id, 64'(rdy), 64'(1));
        chk("rst_mem_wr", id, 64'(wr), 64'(0));
        chk("rst_done", id, 64'(dn), 64'(0));
        chk("rst_err", id, 64'(er), 64'(0));
        chk("rst_mem_addr", id, addr, 64'(0));
        chk("rst_mem_wdata", id, wdata, 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   c0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < 3; i++) begin lasta[i] = '0; lastw[i] = '0; end

        //            sz     addr      data          rdata         wr    er   lat             eaddr     ewdata
        vecs[0] = '{2'b00, 32'h100, 32'hCAFEBABE, 32'h0,        1'b1, 1'b0, 1,            32'h100, 32'hCAFEBABE};
        vecs[1] = '{2'b10, 32'h103, 32'h000000AA, 32'h11223344, 1'b1, 1'b0, 2,            32'h100, 32'hAA223344};
        vecs[2] = '{2'b01, 32'h102, 32'h0000BEEF, 32'h11223344, 1'b1, 1'b0, 2,            32'h100, 32'hBEEF3344};
        vecs[3] = '{2'b10, 32'h200, 32'hFFFFFF55, 32'h11223344, 1'b1, 1'b0, 2,            32'h200, 32'h11223355};
        vecs[4] = '{2'b10, 32'h101, 32'h00000077, 32'hAABBCCDD, 1'b1, 1'b0, 2,            32'h100, 32'hAABB77DD};
        vecs[5] = '{2'b01, 32'h100, 32'h12345678, 32'hAABBCCDD, 1'b1, 1'b0, 2,            32'h100, 32'hAABB5678};
        vecs[6] = '{2'b01, 32'h101, 32'h0000BEEF, 32'h11223344, !CHK, CHK,  CHK ? 1 : 2,  32'h100, 32'h1122BEEF};
        vecs[7] = '{2'b00, 32'h102, 32'h01020304, 32'h0,        !CHK, CHK,  1,            32'h100, 32'h01020304};
        vecs[8] = '{2'b11, 32'h300, 32'h12345678, 32'h0,        1'b0, CHK,  1,            32'h0,   32'h0};
        vecs[9] = '{2'b01, 32'h103, 32'h0000ABCD, 32'h0,        !CHK, CHK,  CHK ? 1 : 2,  32'h100, 32'hABCD0000};

        reset_n = 1'b0;
        b32.req_valid = 1'b0; b32.req_addr = '0; b32.req_data = '0; b32.req_size = '0; b32.mem_rdata = '0;
        b64.req_valid = 1'b0; b64.req_addr = '0; b64.req_data = '0; b64.req_size = '0; b64.mem_rdata = '0;
        b2.req_valid  = 1'b0; b2.req_addr  = '0; b2.req_data  = '0; b2.req_size  = '0; b2.mem_rdata  = '0;
        step();
        step();
        check_reset_vals(0, b32.req_ready, b32.mem_wr, b32.done, b32.err, 64'(b32.mem_addr), 64'(b32.mem_wdata));
        check_reset_vals(1, b64.req_ready, b64.mem_wr, b64.done, b64.err, 64'(b64.mem_addr), 64'(b64.mem_wdata));
        check_reset_vals(2, b2.req_ready,  b2.mem_wr,  b2.done,  b2.err,  64'(b2.mem_addr),  64'(b2.mem_wdata));
        reset_n = 1'b1;
        step();

        // Table of single stores on the 32-bit, RD_LAT=1 instance
        for (int i = 0; i < 10; i++) begin
            e.cyc = vecs[i].lat; e.wr = vecs[i].wr; e.er = vecs[i].er;
            e.addr = 64'(vecs[i].eaddr); e.wdata = 64'(vecs[i].ewdata);
            send(0, vecs[i].addr, 64'(vecs[i].data), vecs[i].sz, 64'(vecs[i].rdata), e);
        end

        // 64-bit lanes with RD_LAT=3
        e = '{4, 1'b1, 1'b0, 64'h208, 64'hBEEF111111111111};
        send(1, 32'h20E, 64'h000000000000BEEF, 2'b01, 64'h1111111111111111, e);
        e = '{1, 1'b1, 1'b0, 64'h208, 64'hFEDCBA9876543210};
        send(1, 32'h208, 64'hFEDCBA9876543210, 2'b00, 64'h0, e);

        // Byte store with valid held: second request waits until IDLE, data latched
        wait_ready(1);
        c0 = cyc;
        b64.req_addr = 32'h205; b64.req_data = 64'h5A; b64.req_size = 2'b10;
        b64.mem_rdata = 64'h0; b64.req_valid = 1'b1;
        q64.push_back('{c0 + 4, 1'b1, 1'b0, 64'h200, 64'h00005A0000000000});
        q64.push_back('{c0 + 6, 1'b1, 1'b0, 64'h300, 64'h0123456789ABCDEF});
        step();
        b64.req_addr = 32'h300; b64.req_data = 64'h0123456789ABCDEF; b64.req_size = 2'b00;
        for (int k = 2; k <= 4; k++) begin
            chk("busy_not_ready", 1, 64'(b64.req_ready), 64'(0));
            step();
        end
        chk("busy_not_ready", 1, 64'(b64.req_ready), 64'(0));
        step();
        chk("ready_after_write", 1, 64'(b64.req_ready), 64'(1));
        step();
        b64.req_valid = 1'b0;
        drain(1);

        // Reset in the middle of a read on the RD_LAT=2 instance
        wait_ready(2);
        b2.req_addr = 32'h103; b2.req_data = 32'hAA; b2.req_size = 2'b10;
        b2.mem_rdata = 32'h11223344; b2.req_valid = 1'b1;
        step();
        b2.req_valid = 1'b0;
        chk("reading_not_ready", 2, 64'(b2.req_ready), 64'(0));
        reset_n = 1'b0;
        #1;
        chk("rst_mid_read_wr", 2, 64'(b2.mem_wr), 64'(0));
        chk("rst_mid_read_ready", 2, 64'(b2.req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin lasta[i] = '0; lastw[i] = '0; end
        for (int k = 0; k < 3; k++) step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("ready_after_release", 2, 64'(b2.req_ready), 64'(1));
        chk("no_partial_write", 2, 64'(b2.mem_wdata), 64'(0));
        e = '{3, 1'b1, 1'b0, 64'h100, 64'h11CC3344};
        send(2, 32'h102, 64'hCC, 2'b10, 64'h11223344, e);

        for (int k = 0; k < 3; k++) step();
        chk("queues_empty", 0, 64'(q32.size() + q64.size() + q2.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
